gpio_port_ctrl: RTL
===================

# gpio_port_ctrl

Parametrised GPIO port controller on the Avalon data bus, and the next generation of the peripheral GPIO interface. Provides NUM_PINS bidirectional pins with per-pin direction, atomic set/clear/toggle of outputs, two-flop input synchronisation, and per-pin rising/falling-edge interrupt capture with a write-one-to-clear status register. Sits behind the bus decoder next to the other peripherals. Its single level interrupt goes to the core's interrupt input.

## Interface
- NUM_PINS, 16, number of GPIO pins (1..32)
- ADDR_SEL_BITS, 0, upper address bits consumed by the bus decoder
- i_Clk  in  1  system clock; every flop is on its rising edge
- i_Rst_n  in  1  asynchronous, active-low reset
- i_SlaveSel  in  1  decoder select for this peripheral
- i_RegAddr  in  30-ADDR_SEL_BITS  word address of the register
- i_AV_ByteEn  in  4  byte enables for writes
- i_AV_Read  in  1  read strobe
- i_AV_Write  in  1  write strobe
- o_AV_ReadData  out  32  registered read data
- i_AV_WriteData  in  32  write data
- o_AV_WaitRequest  out  1  tied low; the block never stalls
- i_Gpio_In  in  NUM_PINS  raw asynchronous pad inputs
- o_Gpio_Out  out  NUM_PINS  output value register
- o_Gpio_OE  out  NUM_PINS  output enable, equal to DDR (1 = drive)
- o_Irq  out  1  OR of all IRQ_STATUS bits

## Operation
- Register map (word address):
  - 0 IN (RO): synchronised pins
  - 1 OUT (RW)
  - 2 DDR (RW)
  - 3 OUT_SET (WO)
  - 4 OUT_CLR (WO)
  - 5 OUT_TGL (WO)
  - 6 RISE_EN (RW)
  - 7 FALL_EN (RW)
  - 8 IRQ_STATUS (RO, W1C)
- Bit k of each register maps to pin k. Bits at and above NUM_PINS read 0 and ignore writes.
- Write-only registers (3, 4, 5) read 0. Writes to IN are ignored.
- Unmapped addresses read 0, and writes to them have no effect.
- Every write is masked per byte by i_AV_ByteEn. This includes SET, CLR, TGL and W1C.
- Transactions act only when i_SlaveSel is high. When i_SlaveSel is low, or no read is in progress, o_AV_ReadData returns to 0 on the next cycle.
- The input path has three stages: sync1 <= i_Gpio_In, sync2 <= sync1, prev <= sync2.
  - IN reads sync2.
  - rise = sync2 & ~prev; fall = ~sync2 & prev.
- IRQ_STATUS bit update, per cycle: next = (status & ~w1c_mask) | (rise & RISE_EN) | (fall & FALL_EN).
  - If a new edge and a W1C hit the same bit in the same cycle, the set wins.
  - Clearing an enable does not clear pending status.
- Pins configured as outputs still sample their pad through IN, so the driven level can be read back.

## Timing
- Reset: all registers, sync flops, o_AV_ReadData, o_Gpio_Out, o_Gpio_OE and o_Irq go to 0.
  - Pins start as inputs.
  - prev resets to 0, so a pad held high out of reset produces one rise event. That event is captured only if RISE_EN is set.
- Read latency is 1: data from a read presented at clock edge n is valid after edge n+1.
- Write latency is 1: the register, o_Gpio_Out and o_Gpio_OE update at the edge that samples the write.
- A read and a write to the same address in the same cycle return the old value.
- Pad-change latency, for a pad that changes before edge k:
  - sync1 captures it at k.
  - IN reflects it after k+1.
  - IRQ_STATUS is set and o_Irq rises after k+2.
- o_Irq is combinational from the status flops and has no further delay.
- Pulses shorter than one clock may be missed. This is the accepted behaviour.
- o_AV_WaitRequest is 0 in every cycle, including during reset.

## Structure
- Package gpio_pkg holds the register address constants (0..8) and the constant MAX_PINS = 32.
- One sub-module: gpio_sync_edge (parameter WIDTH).
  - Contains the 2-flop synchroniser plus the prev stage.
  - Outputs the synchronised value, rise and fall.
  - Has async active-low reset.
- The top level contains:
  - address decode
  - read mux register
  - OUT/DDR/RISE_EN/FALL_EN/IRQ_STATUS registers with byte-enable masking

## Test plan
- Reset check, NUM_PINS=16: after reset, all 9 addresses read 0, o_Gpio_OE=0, o_Irq=0, o_AV_WaitRequest=0.
- Output ops: write DDR=0x00FF and OUT=0x1234, then OUT_SET 0x0001, OUT_CLR 0x0030, OUT_TGL 0x8000.
  - OUT reads 0x9205.
  - o_Gpio_Out=0x9205 one cycle after each write.
  - o_Gpio_OE=0x00FF.
- Byte enables: write OUT=0xFFFF with ByteEn=0b0010 from 0 -> OUT reads 0xFF00. Writing 0xFFFFFFFF to OUT with NUM_PINS=16 -> OUT reads 0x0000FFFF.
- Edge IRQ: RISE_EN=0x0004, FALL_EN=0x0008; drive pin 2 low->high and pin 3 high->low.
  - IRQ_STATUS reads 0x000C.
  - o_Irq rises exactly 3 edges after the pad change.
  - A pin 5 toggle sets nothing.
- W1C race: a W1C 0x0004 coincides with a new pin-2 rise -> bit 2 stays set. A later W1C 0x000C with no edges -> status 0, o_Irq low next cycle.
- Reset mid-operation: assert i_Rst_n low during a write with status pending -> all outputs go to 0 immediately, without waiting for a clock. After release, registers read 0 and the pending write is lost.

Source files
------------

// File: rtl/gpio_pkg.sv
// Shared register map and limits for the GPIO port controller.
package gpio_pkg;

   localparam int MAX_PINS = 32;

   localparam logic [3:0] REG_IN         = 4'd0;
   localparam logic [3:0] REG_OUT        = 4'd1;
   localparam logic [3:0] REG_DDR        = 4'd2;
   localparam logic [3:0] REG_OUT_SET    = 4'd3;
   localparam logic [3:0] REG_OUT_CLR    = 4'd4;
   localparam logic [3:0] REG_OUT_TGL    = 4'd5;
   localparam logic [3:0] REG_RISE_EN    = 4'd6;
   localparam logic [3:0] REG_FALL_EN    = 4'd7;
   localparam logic [3:0] REG_IRQ_STATUS = 4'd8;
   localparam int         NUM_REGS       = 9;

endpackage

// File: rtl/gpio_sync_edge.sv
// Two-flop pad synchroniser plus a history stage for rise/fall detection.
module gpio_sync_edge #(
   parameter int WIDTH = 16
) (
   input  logic             i_Clk,
   input  logic             i_Rst_n,
   input  logic [WIDTH-1:0] i_Async,
   output logic [WIDTH-1:0] o_Sync,
   output logic [WIDTH-1:0] o_Rise,
   output logic [WIDTH-1:0] o_Fall
);

   logic [WIDTH-1:0] r_sync1;
   logic [WIDTH-1:0] r_sync2;
   logic [WIDTH-1:0] r_prev;

   // prev clears to 0, so a pad held high out of reset yields one rise.
   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
         r_prev  <= '0;
      end else begin
         r_sync1 <= i_Async;
         r_sync2 <= r_sync1;
         r_prev  <= r_sync2;
      end
   end

   assign o_Sync = r_sync2;
   assign o_Rise = r_sync2 & ~r_prev;
   assign o_Fall = ~r_sync2 & r_prev;

endmodule

// File: rtl/gpio_port_ctrl.sv
// Avalon-attached GPIO port: direction, atomic set/clear/toggle, and
// byte-masked edge interrupt capture with write-one-to-clear status.
module gpio_port_ctrl
   import gpio_pkg::*;
#(
   parameter int NUM_PINS      = 16,
   parameter int ADDR_SEL_BITS = 0
) (
   input  logic                      i_Clk,
   input  logic                      i_Rst_n,
   input  logic                      i_SlaveSel,
   input  logic [30-ADDR_SEL_BITS-1:0] i_RegAddr,
   input  logic [3:0]                i_AV_ByteEn,
   input  logic                      i_AV_Read,
   input  logic                      i_AV_Write,
   output logic [31:0]               o_AV_ReadData,
   input  logic [31:0]               i_AV_WriteData,
   output logic                      o_AV_WaitRequest,
   input  logic [NUM_PINS-1:0]       i_Gpio_In,
   output logic [NUM_PINS-1:0]       o_Gpio_Out,
   output logic [NUM_PINS-1:0]       o_Gpio_OE,
   output logic                      o_Irq
);

   localparam int AW = 30 - ADDR_SEL_BITS;

   logic [NUM_PINS-1:0] r_out;
   logic [NUM_PINS-1:0] r_ddr;
   logic [NUM_PINS-1:0] r_rise_en;
   logic [NUM_PINS-1:0] r_fall_en;
   logic [NUM_PINS-1:0] r_stat;
   logic [31:0]         r_rdata;

   logic [NUM_PINS-1:0] w_sync;
   logic [NUM_PINS-1:0] w_rise;
   logic [NUM_PINS-1:0] w_fall;
   logic [31:0]         w_bmask;
   logic [NUM_PINS-1:0] w_wen;
   logic [NUM_PINS-1:0] w_wdat;
   logic [NUM_PINS-1:0] w_w1c;
   logic [NUM_REGS-1:0] w_hit;
   logic [MAX_PINS-1:0] w_rmux;
   logic                w_wr;
   logic                w_rd;
   logic                w_unused;

   gpio_sync_edge #(.WIDTH(NUM_PINS)) u_sync (
      .i_Clk   (i_Clk),
      .i_Rst_n (i_Rst_n),
      .i_Async (i_Gpio_In),
      .o_Sync  (w_sync),
      .o_Rise  (w_rise),
      .o_Fall  (w_fall)
   );

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_dec
      assign w_hit[g] = (i_RegAddr == AW'(g));
   end

   for (genvar b = 0; b < 4; b++) begin : g_be
      assign w_bmask[8*b +: 8] = {8{i_AV_ByteEn[b]}};
   end

   assign w_wr   = i_SlaveSel & i_AV_Write;
   assign w_rd   = i_SlaveSel & i_AV_Read;
   // Bits beyond NUM_PINS simply fall off here, so they read 0 and ignore writes.
   assign w_wen  = w_bmask[NUM_PINS-1:0];
   assign w_wdat = i_AV_WriteData[NUM_PINS-1:0] & w_wen;
   assign w_w1c  = (w_wr && w_hit[REG_IRQ_STATUS]) ? w_wdat : '0;

   always_comb begin
      w_rmux = '0;
      if (w_hit[REG_IN])              w_rmux[NUM_PINS-1:0] = w_sync;
      else if (w_hit[REG_OUT])        w_rmux[NUM_PINS-1:0] = r_out;
      else if (w_hit[REG_DDR])        w_rmux[NUM_PINS-1:0] = r_ddr;
      else if (w_hit[REG_RISE_EN])    w_rmux[NUM_PINS-1:0] = r_rise_en;
      else if (w_hit[REG_FALL_EN])    w_rmux[NUM_PINS-1:0] = r_fall_en;
      else if (w_hit[REG_IRQ_STATUS]) w_rmux[NUM_PINS-1:0] = r_stat;
   end

   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         r_out     <= '0;
         r_ddr     <= '0;
         r_rise_en <= '0;
         r_fall_en <= '0;
         r_stat    <= '0;
         r_rdata   <= '0;
      end else begin
         r_rdata <= w_rd ? w_rmux : '0;
         if (w_wr && w_hit[REG_OUT])          r_out <= (r_out & ~w_wen) | w_wdat;
         else if (w_wr && w_hit[REG_OUT_SET]) r_out <= r_out | w_wdat;
         else if (w_wr && w_hit[REG_OUT_CLR]) r_out <= r_out & ~w_wdat;
         else if (w_wr && w_hit[REG_OUT_TGL]) r_out <= r_out ^ w_wdat;
         if (w_wr && w_hit[REG_DDR])     r_ddr     <= (r_ddr & ~w_wen) | w_wdat;
         if (w_wr && w_hit[REG_RISE_EN]) r_rise_en <= (r_rise_en & ~w_wen) | w_wdat;
         if (w_wr && w_hit[REG_FALL_EN]) r_fall_en <= (r_fall_en & ~w_wen) | w_wdat;
         // A fresh edge outranks a same-cycle clear of the same bit.
         r_stat <= (r_stat & ~w_w1c) | (w_rise & r_rise_en) | (w_fall & r_fall_en);
      end
   end

   assign o_AV_ReadData    = r_rdata;
   assign o_AV_WaitRequest = 1'b0;
   assign o_Gpio_Out       = r_out;
   assign o_Gpio_OE        = r_ddr;
   assign o_Irq            = |r_stat;
   assign w_unused         = ^{i_AV_WriteData, w_bmask};

endmodule
